// File: rtl/ddr_req_arbiter_pkg.sv
// ddr_req_arbiter_pkg
//   Shared types for the DDR request arbiter.
//   arb_state_t : arbiter FSM states (IDLE/WR_RUN/RD_RUN/RD_DRAIN/GAP).
//   in_transfer : true while a requester owns the rd_wr_path port.
package ddr_req_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_RUN   = 3'd1,
        ST_RD_RUN   = 3'd2,
        ST_RD_DRAIN = 3'd3,
        ST_GAP      = 3'd4
    } arb_state_t;

    function automatic logic in_transfer(input arb_state_t s);
        return (s == ST_WR_RUN) || (s == ST_RD_RUN) || (s == ST_RD_DRAIN);
    endfunction

endpackage

// File: rtl/ddr_req_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick. Scans req_i starting at rr_ptr_i+1 with
//   wrap-around and returns the first set request.
//   req_i    : pending requests
//   rr_ptr_i : index of the most recently granted requester
//   gnt_o    : one-hot pick (zero when nothing pending)
//   idx_o    : binary index of the pick
//   valid_o  : a pick was made
module rr_arbiter
    import ddr_req_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    int unsigned pos;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = 0;
        // i runs 1..NUM_REQ so the last candidate checked is rr_ptr itself
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            pos = (int'(rr_ptr_i) + i) % NUM_REQ;
            if (!valid_o && req_i[pos]) begin
                valid_o    = 1'b1;
                idx_o      = IDX_W'(pos);
                gnt_o[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr_req_arbiter.sv
// ddr_req_arbiter
//   Shares one rd_wr_path DDR port between NUM_REQ requesters. A round-robin
//   pick latches the winner's command, drives the path, routes write-fetch
//   strobes and read beats to the winner, and releases the port only after
//   the transfer (including all read beats) has completed, followed by a
//   one-cycle GAP so rd_wr_path can return to idle.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   init_calib_complete_i    : MIG calibration done; no grant while low
//   req_i/req_wr_i           : per-requester request and direction (1=write)
//   req_addr_i/burst/wr_data : per-requester command and write data, packed
//   gnt_o, done_o            : one-hot grant, 1-cycle completion pulse
//   fetch_data_en_o          : write-data pop to the granted requester
//   rd_data_valid_o, rd_data_o : read beats to the granted requester
//   path_*_o / path_*_i      : connection to rd_wr_path
module ddr_req_arbiter
    import ddr_req_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned ADDR_WIDTH     = 30,
    parameter int unsigned DATA_WIDTH     = 512,
    parameter int unsigned DATA_NUM_BITS  = 16,
    parameter int unsigned RD_EXTRA_BEATS = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             init_calib_complete_i,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ-1:0]               req_wr_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [NUM_REQ*DATA_NUM_BITS-1:0] req_burst_num_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wr_data_i,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [NUM_REQ-1:0]               done_o,
    output logic [NUM_REQ-1:0]               fetch_data_en_o,
    output logic [NUM_REQ-1:0]               rd_data_valid_o,
    output logic [DATA_WIDTH-1:0]            rd_data_o,
    output logic                             path_wr_en_o,
    output logic                             path_rd_en_o,
    output logic [ADDR_WIDTH-1:0]            path_start_addr_o,
    output logic [DATA_NUM_BITS-1:0]         path_burst_num_o,
    output logic [DATA_WIDTH-1:0]            path_wr_data_o,
    input  logic                             path_fetch_data_en_i,
    input  logic                             path_wr_done_i,
    input  logic                             path_rd_done_i,
    input  logic                             path_rd_data_valid_i,
    input  logic [DATA_WIDTH-1:0]            path_rd_data_i
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = DATA_NUM_BITS + 1;

    arb_state_t               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]       gnt_q, gnt_d;
    logic [NUM_REQ-1:0]       done_q, done_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_NUM_BITS-1:0] burst_q, burst_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_inc, beat_target;

    logic [NUM_REQ-1:0]       pick_onehot;
    logic [IDX_W-1:0]         pick_idx;
    logic                     pick_valid;
    logic                     rd_window;

    logic [ADDR_WIDTH-1:0]    addr_arr  [NUM_REQ];
    logic [DATA_NUM_BITS-1:0] burst_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]    wdata_arr [NUM_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            burst_arr[i] = req_burst_num_i[i*DATA_NUM_BITS +: DATA_NUM_BITS];
            wdata_arr[i] = req_wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i    (req_i),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    assign rd_window   = (state_q == ST_RD_RUN) || (state_q == ST_RD_DRAIN);
    assign beat_target = CNT_W'(burst_q) + CNT_W'(RD_EXTRA_BEATS);
    // Saturating beat count including the beat on the bus this cycle
    assign cnt_inc     = (path_rd_data_valid_i && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
            gnt_q    <= '0;
            done_q   <= '0;
            addr_q   <= '0;
            burst_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            addr_q   <= addr_d;
            burst_q  <= burst_d;
            cnt_q    <= cnt_d;
        end
    end

    // Enables and grant are decoded from the state register, so leaving a
    // RUN state on a done input drops them on the following cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        addr_d   = addr_q;
        burst_d  = burst_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (init_calib_complete_i && pick_valid) begin
                    idx_d    = pick_idx;
                    rr_ptr_d = pick_idx;
                    gnt_d    = pick_onehot;
                    addr_d   = addr_arr[pick_idx];
                    burst_d  = burst_arr[pick_idx];
                    state_d  = req_wr_i[pick_idx] ? ST_WR_RUN : ST_RD_RUN;
                end
            end
            ST_WR_RUN: begin
                if (!init_calib_complete_i) begin
                    state_d = ST_IDLE;
                end else if (path_wr_done_i) begin
                    done_d  = gnt_q;
                    state_d = ST_GAP;
                end
            end
            ST_RD_RUN: begin
                if (!init_calib_complete_i) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (path_rd_done_i) begin
                        state_d = ST_RD_DRAIN;
                    end
                end
            end
            ST_RD_DRAIN: begin
                if (!init_calib_complete_i) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    // >= also covers every beat having arrived before rd_done
                    if (cnt_inc >= beat_target) begin
                        done_d  = gnt_q;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign gnt_o             = in_transfer(state_q) ? gnt_q : '0;
    assign done_o            = done_q;
    assign path_wr_en_o      = (state_q == ST_WR_RUN);
    assign path_rd_en_o      = (state_q == ST_RD_RUN);
    assign path_start_addr_o = addr_q;
    assign path_burst_num_o  = burst_q;
    assign path_wr_data_o    = path_wr_en_o ? wdata_arr[idx_q] : '0;
    assign fetch_data_en_o   = (path_wr_en_o && path_fetch_data_en_i) ? gnt_q : '0;
    assign rd_data_valid_o   = (rd_window && path_rd_data_valid_i) ? gnt_q : '0;
    assign rd_data_o         = path_rd_data_i;

    // Read beats outside the read window are dropped; they indicate a
    // rd_wr_path protocol error.
    a_no_stray_beats: assert property (@(posedge clk_i) disable iff (rst_i)
        path_rd_data_valid_i |-> rd_window);

endmodule

// File: tb/tb_ddr_req_arbiter.sv
module tb_ddr_req_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned AW = 30;
    localparam int unsigned DW = 512;
    localparam int unsigned NB = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           calib = 1'b1;
    logic [NR-1:0]  req = '0;
    logic [NR-1:0]  req_wr = '0;
    logic [AW-1:0]  addr [NR];
    logic [NB-1:0]  burst [NR];
    logic [DW-1:0]  wdata [NR];
    logic [NR*AW-1:0] req_addr;
    logic [NR*NB-1:0] req_burst;
    logic [NR*DW-1:0] req_wdata;

    logic [NR-1:0]  gnt, done, fetch_en, rd_valid;
    logic [DW-1:0]  rd_data, p_wr_data;
    logic           p_wr_en, p_rd_en;
    logic [AW-1:0]  p_addr;
    logic [NB-1:0]  p_burst;
    logic           p_fetch = 1'b0, p_wr_done = 1'b0, p_rd_done = 1'b0, p_rd_valid = 1'b0;
    logic [DW-1:0]  p_rd_data = '0;

    int vec = 0;
    int miss = 0;

    assign req_addr  = {addr[2], addr[1], addr[0]};
    assign req_burst = {burst[2], burst[1], burst[0]};
    assign req_wdata = {wdata[2], wdata[1], wdata[0]};

    always #5 clk = ~clk;

    ddr_req_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .DATA_NUM_BITS  (NB),
        .RD_EXTRA_BEATS (1)
    ) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .init_calib_complete_i (calib),
        .req_i                 (req),
        .req_wr_i              (req_wr),
        .req_addr_i            (req_addr),
        .req_burst_num_i       (req_burst),
        .req_wr_data_i         (req_wdata),
        .gnt_o                 (gnt),
        .done_o                (done),
        .fetch_data_en_o       (fetch_en),
        .rd_data_valid_o       (rd_valid),
        .rd_data_o             (rd_data),
        .path_wr_en_o          (p_wr_en),
        .path_rd_en_o          (p_rd_en),
        .path_start_addr_o     (p_addr),
        .path_burst_num_o      (p_burst),
        .path_wr_data_o        (p_wr_data),
        .path_fetch_data_en_i  (p_fetch),
        .path_wr_done_i        (p_wr_done),
        .path_rd_done_i        (p_rd_done),
        .path_rd_data_valid_i  (p_rd_valid),
        .path_rd_data_i        (p_rd_data)
    );

    // Inputs are driven 2 time units after the edge; outputs checked 1 unit later.
    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req_wr = '0;
        p_fetch = 1'b0; p_wr_done = 1'b0; p_rd_done = 1'b0; p_rd_valid = 1'b0;
        next(); next();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] pat;
        pat = {16{32'hDEAD_BEEF}};
        do_reset();
        p_rd_data = pat;
        #1;
        vec++; if (gnt !== 3'b000) begin miss++; $display("FAIL rst_gnt got=%b exp=000", gnt); end
        vec++; if (done !== 3'b000) begin miss++; $display("FAIL rst_done got=%b exp=000", done); end
        vec++; if ({p_wr_en, p_rd_en} !== 2'b00) begin miss++; $display("FAIL rst_en got=%b exp=00", {p_wr_en, p_rd_en}); end
        vec++; if (p_addr !== 30'd0 || p_burst !== 16'd0) begin miss++; $display("FAIL rst_cmd got=%h/%h exp=0/0", p_addr, p_burst); end
        vec++; if (rd_data !== pat) begin miss++; $display("FAIL rst_rd_data got=%h exp=%h", rd_data, pat); end
    endtask

    task automatic test_write();
        do_reset();
        addr[0] = 30'h0000_1000; burst[0] = 16'd4; wdata[0] = {16{32'h0000_1111}};
        req = 3'b001; req_wr = 3'b001;
        next(); #1;
        vec++; if (gnt !== 3'b001) begin miss++; $display("FAIL wr_gnt got=%b exp=001", gnt); end
        vec++; if ({p_wr_en, p_rd_en} !== 2'b10) begin miss++; $display("FAIL wr_en got=%b exp=10", {p_wr_en, p_rd_en}); end
        vec++; if (p_addr !== 30'h0000_1000 || p_burst !== 16'd4) begin miss++; $display("FAIL wr_cmd got=%h/%h exp=1000/4", p_addr, p_burst); end
        vec++; if (p_wr_data !== {16{32'h0000_1111}}) begin miss++; $display("FAIL wr_data got=%h", p_wr_data); end
        for (int b = 0; b < 4; b++) begin
            next();
            p_fetch = 1'b1;
            addr[0] = 30'h0000_2000; burst[0] = 16'd9;
            #1;
            vec++; if (fetch_en !== 3'b001) begin miss++; $display("FAIL wr_fetch%0d got=%b exp=001", b, fetch_en); end
            vec++; if (p_addr !== 30'h0000_1000 || p_burst !== 16'd4) begin miss++; $display("FAIL wr_latched%0d got=%h/%h exp=1000/4", b, p_addr, p_burst); end
        end
        next(); p_fetch = 1'b0; p_wr_done = 1'b1; #1;
        vec++; if (fetch_en !== 3'b000 || done !== 3'b000) begin miss++; $display("FAIL wr_pre_done got=%b/%b exp=000/000", fetch_en, done); end
        next(); p_wr_done = 1'b0; req = '0; #1;
        vec++; if (done !== 3'b001) begin miss++; $display("FAIL wr_done got=%b exp=001", done); end
        vec++; if (gnt !== 3'b000 || p_wr_en !== 1'b0) begin miss++; $display("FAIL wr_gap got=%b/%b exp=000/0", gnt, p_wr_en); end
        next(); #1;
        vec++; if (done !== 3'b000) begin miss++; $display("FAIL wr_done_pulse got=%b exp=000", done); end
    endtask

    task automatic test_read_drain();
        do_reset();
        addr[1] = 30'h0ABC_0040; burst[1] = 16'd3;
        req = 3'b010; req_wr = 3'b000;
        next(); #1;
        vec++; if (gnt !== 3'b010 || {p_wr_en, p_rd_en} !== 2'b01) begin miss++; $display("FAIL rd_gnt got=%b/%b exp=010/01", gnt, {p_wr_en, p_rd_en}); end
        vec++; if (p_addr !== 30'h0ABC_0040 || p_burst !== 16'd3) begin miss++; $display("FAIL rd_cmd got=%h/%h exp=abc0040/3", p_addr, p_burst); end
        for (int b = 0; b < 3; b++) begin
            next();
            p_rd_valid = 1'b1; p_rd_data = {16{32'hC0DE_0000 + 32'(b)}};
            #1;
            vec++; if (rd_valid !== 3'b010) begin miss++; $display("FAIL rd_beat%0d got=%b exp=010", b, rd_valid); end
        end
        next(); p_rd_valid = 1'b0; p_rd_done = 1'b1; #1;
        vec++; if (rd_valid !== 3'b000) begin miss++; $display("FAIL rd_novalid got=%b exp=000", rd_valid); end
        next(); p_rd_done = 1'b0; #1;
        vec++; if (gnt !== 3'b010 || p_rd_en !== 1'b0 || done !== 3'b000) begin miss++; $display("FAIL rd_drain got=%b/%b/%b exp=010/0/000", gnt, p_rd_en, done); end
        next(); p_rd_valid = 1'b1; p_rd_data = {16{32'hC0DE_0003}}; #1;
        vec++; if (rd_valid !== 3'b010 || gnt !== 3'b010) begin miss++; $display("FAIL rd_beat4 got=%b/%b exp=010/010", rd_valid, gnt); end
        vec++; if (rd_data !== {16{32'hC0DE_0003}}) begin miss++; $display("FAIL rd_data got=%h", rd_data); end
        next(); p_rd_valid = 1'b0; req = '0; #1;
        vec++; if (done !== 3'b010 || gnt !== 3'b000) begin miss++; $display("FAIL rd_done got=%b/%b exp=010/000", done, gnt); end
    endtask

    task automatic test_two_requesters();
        do_reset();
        addr[0] = 30'h100; burst[0] = 16'd1;
        addr[2] = 30'h300; burst[2] = 16'd1; wdata[2] = {16{32'h2222_2222}};
        req = 3'b101; req_wr = 3'b100;
        next(); p_rd_valid = 1'b1; #1;
        vec++; if (gnt !== 3'b001 || {p_wr_en, p_rd_en} !== 2'b01) begin miss++; $display("FAIL two_first got=%b/%b exp=001/01", gnt, {p_wr_en, p_rd_en}); end
        next(); p_rd_done = 1'b1; #1;
        vec++; if (rd_valid !== 3'b001) begin miss++; $display("FAIL two_beat got=%b exp=001", rd_valid); end
        // both beats already in before rd_done: drain completes without another beat
        next(); p_rd_valid = 1'b0; p_rd_done = 1'b0; #1;
        vec++; if (gnt !== 3'b001 || {p_wr_en, p_rd_en} !== 2'b00) begin miss++; $display("FAIL two_drain got=%b/%b exp=001/00", gnt, {p_wr_en, p_rd_en}); end
        next(); req = 3'b100; #1;
        vec++; if (done !== 3'b001 || gnt !== 3'b000) begin miss++; $display("FAIL two_done0 got=%b/%b exp=001/000", done, gnt); end
        next(); #1;
        vec++; if (gnt !== 3'b000) begin miss++; $display("FAIL two_idle got=%b exp=000", gnt); end
        next(); p_fetch = 1'b1; #1;
        vec++; if (gnt !== 3'b100 || {p_wr_en, p_rd_en} !== 2'b10) begin miss++; $display("FAIL two_second got=%b/%b exp=100/10", gnt, {p_wr_en, p_rd_en}); end
        vec++; if (fetch_en !== 3'b100 || p_wr_data !== {16{32'h2222_2222}}) begin miss++; $display("FAIL two_wr got=%b data=%h", fetch_en, p_wr_data); end
        next(); p_fetch = 1'b0; p_wr_done = 1'b1; #1;
        next(); p_wr_done = 1'b0; req = '0; #1;
        vec++; if (done !== 3'b100 || {p_wr_en, p_rd_en} !== 2'b00) begin miss++; $display("FAIL two_done2 got=%b/%b exp=100/00", done, {p_wr_en, p_rd_en}); end
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] exp;
        do_reset();
        for (int i = 0; i < 3; i++) begin addr[i] = 30'(i * 16); burst[i] = 16'd1; end
        req = 3'b111; req_wr = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp = 3'b001 << (k % 3);
            next(); p_wr_done = 1'b1; #1;
            vec++; if (gnt !== exp || p_wr_en !== 1'b1) begin miss++; $display("FAIL b2b_gnt%0d got=%b/%b exp=%b/1", k, gnt, p_wr_en, exp); end
            next(); p_wr_done = 1'b0; #1;
            vec++; if (gnt !== 3'b000 || done !== exp || p_wr_en !== 1'b0) begin miss++; $display("FAIL b2b_gap%0d got=%b/%b exp=000/%b", k, gnt, done, exp); end
            next(); #1;
            vec++; if (gnt !== 3'b000 || done !== 3'b000) begin miss++; $display("FAIL b2b_idle%0d got=%b/%b exp=000/000", k, gnt, done); end
        end
        req = '0;
    endtask

    task automatic test_calib();
        do_reset();
        calib = 1'b0; req = 3'b111; req_wr = 3'b000;
        for (int c = 0; c < 3; c++) begin
            next(); #1;
            vec++; if (gnt !== 3'b000 || p_rd_en !== 1'b0) begin miss++; $display("FAIL calib_hold%0d got=%b/%b exp=000/0", c, gnt, p_rd_en); end
        end
        calib = 1'b1;
        next(); #1;
        vec++; if (gnt !== 3'b001 || p_rd_en !== 1'b1) begin miss++; $display("FAIL calib_gnt got=%b/%b exp=001/1", gnt, p_rd_en); end
        req = '0;
        do_reset();
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        addr[0] = 30'h0000_5000; burst[0] = 16'd8; wdata[0] = {16{32'h5555_AAAA}};
        req = 3'b001; req_wr = 3'b001;
        next();
        for (int b = 0; b < 2; b++) begin next(); p_fetch = 1'b1; end
        rst = 1'b1;
        next(); rst = 1'b0; #1;
        vec++; if (gnt !== 3'b000 || done !== 3'b000 || fetch_en !== 3'b000) begin miss++; $display("FAIL rmw_out got=%b/%b/%b exp=000/000/000", gnt, done, fetch_en); end
        vec++; if ({p_wr_en, p_rd_en} !== 2'b00 || p_addr !== 30'd0 || p_burst !== 16'd0 || p_wr_data !== '0) begin miss++; $display("FAIL rmw_path got=%b/%h/%h exp=00/0/0", {p_wr_en, p_rd_en}, p_addr, p_burst); end
        p_fetch = 1'b0;
        next(); #1;
        vec++; if (gnt !== 3'b001 || p_addr !== 30'h0000_5000 || p_burst !== 16'd8) begin miss++; $display("FAIL rmw_regnt got=%b/%h/%h exp=001/5000/8", gnt, p_addr, p_burst); end
        for (int b = 0; b < 8; b++) begin next(); p_fetch = 1'b1; end
        next(); p_fetch = 1'b0; p_wr_done = 1'b1; #1;
        vec++; if (done !== 3'b000) begin miss++; $display("FAIL rmw_early_done got=%b exp=000", done); end
        next(); p_wr_done = 1'b0; req = '0; #1;
        vec++; if (done !== 3'b001) begin miss++; $display("FAIL rmw_done got=%b exp=001", done); end
    endtask

    // Enables must never overlap and the grant must be one-hot or zero.
    always @(negedge clk) begin
        if (!rst) begin
            vec++;
            if ((p_wr_en && p_rd_en) || !$onehot0(gnt)) begin
                miss++;
                $display("FAIL excl got=en%b%b gnt=%b exp=no_overlap", p_wr_en, p_rd_en, gnt);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin addr[i] = '0; burst[i] = '0; wdata[i] = '0; end
        test_reset();
        test_write();
        test_read_drain();
        test_two_requesters();
        test_back_to_back();
        test_calib();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
